// File: rtl/cci_mpf_shim_tx_buffer.sv
// Elastic FIFO buffer for one CCI-MPF transmit channel (AFU -> QLP).
// Latency: 2 cycles minimum from afu_tx_valid to qlp_tx_valid (no bypass).
// Backpressure: pops stall while qlp_tx_almfull is high; the AFU is throttled by a registered afu_tx_almfull.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   afu_tx_valid/data request from the AFU, accepted unless full with no same-cycle pop
//   afu_tx_almfull    registered; high when post-edge occupancy >= DEPTH - ALMFULL_SLACK (and during reset)
//   qlp_tx_valid/data registered request toward the QLP; data holds when valid is low
//   qlp_tx_almfull    QLP almost-full; when high no entry is popped
//   overflow_err      sticky: a request was dropped for lack of space
//   occupancy         current entry count (debug)

module cci_mpf_shim_tx_buffer #(
  parameter int TX_WIDTH      = 600,
  parameter int DEPTH         = 64,   // power of two, >= 4
  parameter int ALMFULL_SLACK = 8     // 1 <= ALMFULL_SLACK < DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         afu_tx_valid,
  input  logic [TX_WIDTH-1:0]          afu_tx_data,
  output logic                         afu_tx_almfull,
  output logic                         qlp_tx_valid,
  output logic [TX_WIDTH-1:0]          qlp_tx_data,
  input  logic                         qlp_tx_almfull,
  output logic                         overflow_err,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - ALMFULL_SLACK);

  logic [TX_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic                pop;
  logic                push;

  // A push into a full buffer is legal when the same edge pops, since the
  // freed slot is exactly the one the write pointer points at.
  always_comb begin
    pop        = (count != '0) && !qlp_tx_almfull;
    push       = afu_tx_valid && ((count != FULL_CNT) || pop);
    count_next = count + CW'(push) - CW'(pop);
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= afu_tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      qlp_tx_valid   <= 1'b0;
      qlp_tx_data    <= '0;
      overflow_err   <= 1'b0;
      afu_tx_almfull <= 1'b1;
    end else begin
      qlp_tx_valid <= pop;
      if (pop) begin
        // When full with a simultaneous push, rd_ptr == wr_ptr; the
        // non-blocking read returns the old head before it is overwritten.
        qlp_tx_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (afu_tx_valid && !push) begin
        overflow_err <= 1'b1;
      end
      count          <= count_next;
      afu_tx_almfull <= (count_next >= AF_CNT);
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Bench for cci_mpf_shim_tx_buffer: table-driven vectors plus multi-cycle
// sequences, with a queue scoreboard checking order and exactly-once delivery.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_cci_mpf_shim_tx_buffer;

  localparam int W  = 32;
  localparam int D  = 64;
  localparam int S  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          afu_tx_valid = 1'b0;
  logic [W-1:0]  afu_tx_data = '0;
  logic          afu_tx_almfull;
  logic          qlp_tx_valid;
  logic [W-1:0]  qlp_tx_data;
  logic          qlp_tx_almfull = 1'b0;
  logic          overflow_err;
  logic [CW-1:0] occupancy;

  cci_mpf_shim_tx_buffer #(
    .TX_WIDTH      (W),
    .DEPTH         (D),
    .ALMFULL_SLACK (S)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .afu_tx_valid   (afu_tx_valid),
    .afu_tx_data    (afu_tx_data),
    .afu_tx_almfull (afu_tx_almfull),
    .qlp_tx_valid   (qlp_tx_valid),
    .qlp_tx_data    (qlp_tx_data),
    .qlp_tx_almfull (qlp_tx_almfull),
    .overflow_err   (overflow_err),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard / reference state
  logic [W-1:0] q[$];
  int           m_cnt = 0;
  bit           m_ovf = 0;
  bit           m_vld = 0;
  bit           m_alm = 1;
  logic [W-1:0] m_data = '0;
  int           delivered = 0;
  int           accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, compare against the reference.
  task automatic step(input bit v, input logic [W-1:0] d, input bit qa);
    bit p;
    bit u;
    afu_tx_valid   = v;
    afu_tx_data    = d;
    qlp_tx_almfull = qa;
    if (reset) begin
      q.delete();
      m_cnt  = 0;
      m_ovf  = 0;
      m_vld  = 0;
      m_data = '0;
      m_alm  = 1;
    end else begin
      p = (m_cnt != 0) && !qa;
      u = v && ((m_cnt != D) || p);
      m_vld = p;
      if (p) m_data = q.pop_front();
      if (u) begin
        q.push_back(d);
        accepted++;
      end
      if (v && !u) m_ovf = 1;
      m_cnt = m_cnt + int'(u) - int'(p);
      m_alm = (m_cnt >= D - S);
    end
    @(posedge clk);
    #1;
    chk("qlp_tx_valid",   qlp_tx_valid,   m_vld);
    chk("qlp_tx_data",    qlp_tx_data,    m_data);
    chk("occupancy",      occupancy,      m_cnt);
    chk("afu_tx_almfull", afu_tx_almfull, m_alm);
    chk("overflow_err",   overflow_err,   m_ovf);
    if (qlp_tx_valid) delivered++;
  endtask

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           qa;
    bit           e_vld;
    logic [W-1:0] e_data;
    int           e_occ;
    bit           e_alm;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Hand-derived from an empty buffer just out of reset.
    vecs[0] = '{1'b1, 32'h5A, 1'b0, 1'b0, 32'h00, 1, 1'b0};  // push 5A
    vecs[1] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h5A, 0, 1'b0};  // 5A out
    vecs[2] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h5A, 1, 1'b0};  // held, data holds
    vecs[3] = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h5A, 2, 1'b0};
    vecs[4] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 2, 1'b0};  // push+pop
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h11, 2, 1'b0};
    vecs[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h22, 1, 1'b0};
    vecs[7] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h33, 0, 1'b0};
    vecs[8] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h33, 0, 1'b0};

    // Reset values: three cycles held, then release.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hFFFF_FFFF, 1'b0);
      chk("rst_almfull", afu_tx_almfull, 1'b1);
      chk("rst_occ", occupancy, 0);
    end
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("rel_almfull", afu_tx_almfull, 1'b0);
    chk("rel_valid", qlp_tx_valid, 1'b0);

    // Table-driven vectors (includes single-request latency of 2 cycles).
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].qa);
      chk($sformatf("vec%0d_valid", i), qlp_tx_valid, vecs[i].e_vld);
      chk($sformatf("vec%0d_data", i),  qlp_tx_data,  vecs[i].e_data);
      chk($sformatf("vec%0d_occ", i),   occupancy,    vecs[i].e_occ);
      chk($sformatf("vec%0d_alm", i),   afu_tx_almfull, vecs[i].e_alm);
    end

    // Backpressure fill: 56 pushes with QLP almost-full high.
    for (int i = 0; i < 56; i++) begin
      step(1'b1, 32'h1000 + i, 1'b1);
      if (i == 54) chk("bp_alm_before", afu_tx_almfull, 1'b0);
    end
    chk("bp_alm_after56", afu_tx_almfull, 1'b1);
    chk("bp_occ", occupancy, 56);
    for (int i = 0; i < 56; i++) begin
      step(1'b0, '0, 1'b0);
      chk("bp_drain_valid", qlp_tx_valid, 1'b1);
      chk("bp_drain_data", qlp_tx_data, 32'h1000 + i);
    end
    step(1'b0, '0, 1'b0);
    chk("bp_drain_done", qlp_tx_valid, 1'b0);

    // Full with simultaneous push/pop.
    for (int i = 0; i < 64; i++) step(1'b1, 32'h2000 + i, 1'b1);
    chk("full_occ", occupancy, 64);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h3000 + i, 1'b0);
      chk("full_pp_occ", occupancy, 64);
      chk("full_pp_ovf", overflow_err, 1'b0);
    end

    // Overflow: one extra push while full and stalled is dropped.
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("ovf_set", overflow_err, 1'b1);
    chk("ovf_occ", occupancy, 64);
    step(1'b0, '0, 1'b1);
    chk("ovf_sticky", overflow_err, 1'b1);
    for (int i = 0; i < 66; i++) begin
      step(1'b0, '0, 1'b0);
      if (qlp_tx_valid) chk("ovf_dropped_absent", qlp_tx_data == 32'hDEAD_BEEF, 1'b0);
    end
    chk("ovf_sticky_end", overflow_err, 1'b1);

    // Reset mid-operation with 20 buffered entries.
    for (int i = 0; i < 20; i++) step(1'b1, 32'hA000 + i, 1'b1);
    chk("mid_occ20", occupancy, 20);
    reset = 1'b1;
    step(1'b1, 32'hBAD0, 1'b0);
    step(1'b1, 32'hBAD1, 1'b0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", qlp_tx_valid, 1'b0);
    chk("mid_rst_ovf", overflow_err, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b0);
      chk("mid_no_stale", qlp_tx_valid, 1'b0);
    end

    // Stream 200 requests through with sporadic backpressure (pointer wrap).
    delivered = 0;
    accepted  = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 32'h5_0000 + i, ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 100 && m_cnt != 0; i++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("stream_accepted", accepted, 200);
    chk("stream_delivered", delivered, 200);
    chk("stream_queue_empty", q.size(), 0);
    chk("stream_ovf", overflow_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_tx_buffer.md
# cci_mpf_shim_tx_buffer

Elastic request buffer for one CCI-MPF transmit channel (c0Tx or c1Tx), placed between AFU-side request logic and the to_afu side of the MPF interface. It absorbs AFU requests into a FIFO and forwards them toward the QLP only while the QLP's almost-full is low. Toward the AFU it generates its own registered almost-full with configurable slack. One instance is used per channel; the payload is the flattened channel request struct.

## Interface
Parameters:
- TX_WIDTH, default 600: width of the flattened request payload (header plus data) in bits.
- DEPTH, default 64: FIFO entries; must be a power of two and at least 4.
- ALMFULL_SLACK, default 8: free entries reserved after almost-full asserts; 1 ≤ ALMFULL_SLACK < DEPTH.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- afu_tx_valid  in  1  AFU request present this cycle.
- afu_tx_data  in  TX_WIDTH  AFU request payload.
- afu_tx_almfull  out  1  registered almost-full toward the AFU.
- qlp_tx_valid  out  1  registered request valid toward the QLP.
- qlp_tx_data  out  TX_WIDTH  registered request payload toward the QLP.
- qlp_tx_almfull  in  1  QLP almost-full; when high, no pop is permitted.
- overflow_err  out  1  sticky flag: a request arrived with no free entry.
- occupancy  out  $clog2(DEPTH+1)  current entry count, for debug.

## Operation
- Storage: DEPTH × TX_WIDTH circular buffer with log2(DEPTH)-bit read and write pointers. Pointers wrap naturally modulo DEPTH.
- Count register: $clog2(DEPTH+1) bits, range 0..DEPTH. Full when count == DEPTH; empty when count == 0.
- Pop condition, evaluated each edge: `pop = (count != 0) && !qlp_tx_almfull`.
  - On pop, the head entry loads into qlp_tx_data, qlp_tx_valid is set to 1, and the read pointer advances.
  - With no pop, qlp_tx_valid is set to 0 and qlp_tx_data holds its last value.
  - At most one pop per cycle.
- Push condition: `push = afu_tx_valid && ((count != DEPTH) || pop)`.
  - Push while full is allowed when a pop occurs on the same edge.
  - On push, afu_tx_data is written at the write pointer and the write pointer advances.
- Count update: count_next = count + push − pop.
- Overflow: afu_tx_valid while full with no same-cycle pop drops the request, sets overflow_err, and leaves pointers and count unchanged. overflow_err clears only on reset.
- Almost-full: afu_tx_almfull is loaded each edge with `(count_next >= DEPTH − ALMFULL_SLACK)`.
- Ordering: strict FIFO. No reordering, no merging.
- Reset (any cycle, including mid-traffic):
  - Pointers, count, and occupancy go to 0; all buffered contents are discarded.
  - qlp_tx_valid = 0, overflow_err = 0, qlp_tx_data = 0.
  - afu_tx_almfull = 1 while reset is high; it goes to 0 on the first edge with reset low.
  - Inputs are ignored while reset is high.

## Timing
- Request sampled at edge E appears on qlp_tx_valid in the cycle after edge E+1, given qlp_tx_almfull is low at E+1. Minimum latency is 2 cycles; there is no bypass path.
- Sustained throughput is 1 request per cycle when qlp_tx_almfull stays low.
- qlp_tx_almfull sampled high at edge E means qlp_tx_valid = 0 in the cycle after E. Popping resumes on the first edge where it is sampled low.
- afu_tx_almfull reflects occupancy after edge E and is visible in the cycle after E. An AFU that stops issuing within ALMFULL_SLACK−1 cycles of seeing it never overflows.
- occupancy equals count; it is registered and updates with the same timing as afu_tx_almfull.

## Test plan
- **Reset values:** hold reset for 3 cycles, then release. Required: almfull = 1 during reset and 0 after the first low edge; qlp_tx_valid = 0, overflow_err = 0, occupancy = 0.
- **Single request latency:** single push of payload 0x5A at edge 10 with qlp_tx_almfull low. Required: qlp_tx_valid = 1 with data 0x5A in the cycle after edge 11; occupancy returns to 0.
- **Backpressure fill:** with DEPTH = 64, SLACK = 8, hold qlp_tx_almfull high and push 56 requests. Required: afu_tx_almfull rises in the cycle after the 56th push; no qlp_tx_valid. Then release backpressure: all 56 requests emerge in order on 56 consecutive cycles.
- **Full with simultaneous push/pop:** fill to 64, then hold qlp_tx_almfull low while pushing every cycle. Required: pushes are accepted, occupancy stays at 64, and overflow_err stays 0.
- **Overflow:** fill to 64 under backpressure, then push one more request. Required: overflow_err = 1 and stays 1, occupancy = 64, and the dropped payload never appears at the output.
- **Reset mid-operation:** assert reset with 20 entries buffered. Required: occupancy = 0 and qlp_tx_valid = 0; after reset, none of the old 20 payloads are ever emitted. Pointer wrap is exercised by streaming 200 requests through and checking in-order, exactly-once delivery.
